// File: rtl/datapath_sequencer.sv
// datapath_sequencer: queues datapath commands in a small FIFO and replays
// each one (cmd_repeat + 1) times through an IDLE -> ISSUE -> WAIT sequence.
// A repetition lasts two cycles: ISSUE drives the head entry onto the
// register-file/ALU controls, and WAIT holds them at zero while the datapath
// flags settle.
// Optional feature macro: SEQ_FLAG_STOP_EN -- when defined, a WAIT edge whose
// Flags_in intersects the entry's stop mask ends that entry early.
module datapath_sequencer #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [7:0]               cmd_opcode,
  input  logic [3:0]               cmd_rdest,
  input  logic [3:0]               cmd_rsrc,
  input  logic                     cmd_imm_sel,
  input  logic [15:0]              cmd_imm,
  input  logic                     cmd_wb,
  input  logic [3:0]               cmd_repeat,
  input  logic [4:0]               cmd_stop_mask,
  output logic [7:0]               opcode,
  output logic [3:0]               Rdest_sel,
  output logic [3:0]               Rsrc_sel,
  output logic                     Imm_sel,
  output logic [15:0]              Imm_in,
  output logic [15:0]              wEnable,
  input  logic [4:0]               Flags_in,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [4:0]               last_flags
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  typedef struct packed {
    logic [7:0]  opcode;
    logic [3:0]  rdest;
    logic [3:0]  rsrc;
    logic        imm_sel;
    logic [15:0] imm;
    logic        wb;
    logic [3:0]  rpt;
`ifdef SEQ_FLAG_STOP_EN
    logic [4:0]  stop_mask;
`endif
  } entry_t;

  // Write-enable decode: one bit per destination register.
  function automatic logic [15:0] onehot16(input logic [3:0] idx);
    onehot16 = 16'h0001 << idx;
  endfunction

  state_t        state_r;
  state_t        next_state_s;
  entry_t        mem_r [DEPTH];
  entry_t        push_entry_s;
  entry_t        issue_s;
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW-1:0] issue_idx_s;
  logic [3:0]    rep_cnt_r;
  logic          push_s;
  logic          pop_s;
  logic          finish_s;
  logic          new_entry_s;
  logic          stop_s;

  assign cmd_ready = (fifo_count < DEPTH_C);
  assign busy      = (state_r != IDLE) || (fifo_count != CNT_ZERO);
  assign push_s    = cmd_valid & cmd_ready;
  assign pop_s     = finish_s;

  // The entry that will be on the outputs next cycle: a repeat keeps the
  // head, a completed entry hands over to the one behind it.
  assign issue_idx_s = finish_s ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
  assign issue_s     = mem_r[issue_idx_s];

`ifdef SEQ_FLAG_STOP_EN
  entry_t head_s;
  assign head_s = mem_r[rd_ptr_r];
  assign stop_s = |(Flags_in & head_s.stop_mask);
`else
  logic [4:0] unused_stop_mask;
  assign unused_stop_mask = cmd_stop_mask;
  assign stop_s           = 1'b0;
`endif

  // Pack the incoming command into a FIFO entry.
  always_comb begin
    push_entry_s         = '0;
    push_entry_s.opcode  = cmd_opcode;
    push_entry_s.rdest   = cmd_rdest;
    push_entry_s.rsrc    = cmd_rsrc;
    push_entry_s.imm_sel = cmd_imm_sel;
    push_entry_s.imm     = cmd_imm;
    push_entry_s.wb      = cmd_wb;
    push_entry_s.rpt     = cmd_repeat;
`ifdef SEQ_FLAG_STOP_EN
    push_entry_s.stop_mask = cmd_stop_mask;
`endif
  end

  // Next-state logic; finish_s marks the WAIT edge that retires the head.
  always_comb begin
    next_state_s = state_r;
    finish_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (fifo_count != CNT_ZERO) begin
          next_state_s = ISSUE;
        end else begin
          next_state_s = IDLE;
        end
      end
      ISSUE: begin
        next_state_s = WAIT;
      end
      WAIT: begin
        if ((rep_cnt_r != 4'd0) && !stop_s) begin
          next_state_s = ISSUE;
        end else begin
          finish_s = 1'b1;
          if (fifo_count > CNT_ONE) begin
            next_state_s = ISSUE;
          end else begin
            next_state_s = IDLE;
          end
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // A fresh entry starts whenever ISSUE is entered from IDLE or after a retire.
  always_comb begin
    if ((next_state_s == ISSUE) && ((state_r == IDLE) || finish_s)) begin
      new_entry_s = 1'b1;
    end else begin
      new_entry_s = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FIFO storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push_s && !reset) begin
      mem_r[wr_ptr_r] <= push_entry_s;
    end
  end

  // FIFO pointers and occupancy; a push and pop on the same edge cancel.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      fifo_count <= CNT_ZERO;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      if (push_s && !pop_s) begin
        fifo_count <= fifo_count + CNT_ONE;
      end else if (!push_s && pop_s) begin
        fifo_count <= fifo_count - CNT_ONE;
      end
    end
  end

  // Repeat counter: loaded per entry, decremented on each repeating WAIT edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      rep_cnt_r <= 4'd0;
    end else if (new_entry_s) begin
      rep_cnt_r <= issue_s.rpt;
    end else if ((state_r == WAIT) && !finish_s) begin
      rep_cnt_r <= rep_cnt_r - 4'd1;
    end
  end

  // Completion pulse and flag capture, both on the WAIT edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      done       <= 1'b0;
      last_flags <= 5'd0;
    end else begin
      done <= finish_s;
      if (state_r == WAIT) begin
        last_flags <= Flags_in;
      end
    end
  end

  // Datapath controls are registered so they are valid for the whole ISSUE
  // cycle and forced to zero in IDLE and WAIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      opcode    <= 8'd0;
      Rdest_sel <= 4'd0;
      Rsrc_sel  <= 4'd0;
      Imm_sel   <= 1'b0;
      Imm_in    <= 16'd0;
      wEnable   <= 16'd0;
    end else if (next_state_s == ISSUE) begin
      opcode    <= issue_s.opcode;
      Rdest_sel <= issue_s.rdest;
      Rsrc_sel  <= issue_s.rsrc;
      Imm_sel   <= issue_s.imm_sel;
      Imm_in    <= issue_s.imm;
      wEnable   <= issue_s.wb ? onehot16(issue_s.rdest) : 16'd0;
    end else begin
      opcode    <= 8'd0;
      Rdest_sel <= 4'd0;
      Rsrc_sel  <= 4'd0;
      Imm_sel   <= 1'b0;
      Imm_in    <= 16'd0;
      wEnable   <= 16'd0;
    end
  end

endmodule

// File: tb/tb_datapath_sequencer.sv
// Directed testbench for datapath_sequencer (DEPTH=4). Inputs change 1 ns
// after each rising edge and outputs are sampled at the same point.
module tb_datapath_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_opcode;
  logic [3:0]  cmd_rdest;
  logic [3:0]  cmd_rsrc;
  logic        cmd_imm_sel;
  logic [15:0] cmd_imm;
  logic        cmd_wb;
  logic [3:0]  cmd_repeat;
  logic [4:0]  cmd_stop_mask;
  logic [7:0]  opcode;
  logic [3:0]  Rdest_sel;
  logic [3:0]  Rsrc_sel;
  logic        Imm_sel;
  logic [15:0] Imm_in;
  logic [15:0] wEnable;
  logic [4:0]  Flags_in;
  logic        busy;
  logic        done;
  logic [2:0]  fifo_count;
  logic [4:0]  last_flags;

  int n_cmp  = 0;
  int n_fail = 0;

  datapath_sequencer #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_rdest(cmd_rdest), .cmd_rsrc(cmd_rsrc),
    .cmd_imm_sel(cmd_imm_sel), .cmd_imm(cmd_imm), .cmd_wb(cmd_wb),
    .cmd_repeat(cmd_repeat), .cmd_stop_mask(cmd_stop_mask),
    .opcode(opcode), .Rdest_sel(Rdest_sel), .Rsrc_sel(Rsrc_sel),
    .Imm_sel(Imm_sel), .Imm_in(Imm_in), .wEnable(wEnable),
    .Flags_in(Flags_in),
    .busy(busy), .done(done), .fifo_count(fifo_count), .last_flags(last_flags)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input logic [7:0] op, input logic [3:0] rd, input logic [3:0] rs,
                           input logic isel, input logic [15:0] imm, input logic wb,
                           input logic [3:0] rep, input logic [4:0] smask);
    cmd_valid     = 1'b1;
    cmd_opcode    = op;
    cmd_rdest     = rd;
    cmd_rsrc      = rs;
    cmd_imm_sel   = isel;
    cmd_imm       = imm;
    cmd_wb        = wb;
    cmd_repeat    = rep;
    cmd_stop_mask = smask;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    drive_cmd(8'hAA, 4'd1, 4'd2, 1'b1, 16'h1234, 1'b1, 4'd0, 5'd0);
    tick();
    cmd_valid = 1'b0;
    n_cmp++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
    n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (last_flags !== 5'd0) begin n_fail++; $display("FAIL reset_flags: got %h want 0", last_flags); end
    n_cmp++; if ({opcode, Rdest_sel, Rsrc_sel, Imm_sel, Imm_in, wEnable} !== 49'd0) begin
      n_fail++; $display("FAIL reset_outputs: got op=%h wen=%h imm=%h want all 0", opcode, wEnable, Imm_in);
    end
    reset = 1'b0;
  endtask

  task automatic test_single();
    drive_cmd(8'h05, 4'd3, 4'd2, 1'b1, 16'hBEEF, 1'b1, 4'd0, 5'd0);
    tick();  // E0: push
    cmd_valid = 1'b0;
    n_cmp++; if (fifo_count !== 3'd1) begin n_fail++; $display("FAIL single_count_e0: got %0d want 1", fifo_count); end
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_e0: got %b want 1", busy); end
    n_cmp++; if (opcode !== 8'h00) begin n_fail++; $display("FAIL single_idle_op: got %h want 00", opcode); end
    tick();  // E1: ISSUE
    n_cmp++; if (opcode !== 8'h05) begin n_fail++; $display("FAIL single_opcode: got %h want 05", opcode); end
    n_cmp++; if (Rdest_sel !== 4'd3) begin n_fail++; $display("FAIL single_rdest: got %0d want 3", Rdest_sel); end
    n_cmp++; if (Rsrc_sel !== 4'd2) begin n_fail++; $display("FAIL single_rsrc: got %0d want 2", Rsrc_sel); end
    n_cmp++; if (Imm_sel !== 1'b1) begin n_fail++; $display("FAIL single_immsel: got %b want 1", Imm_sel); end
    n_cmp++; if (Imm_in !== 16'hBEEF) begin n_fail++; $display("FAIL single_imm: got %h want beef", Imm_in); end
    n_cmp++; if (wEnable !== 16'h0008) begin n_fail++; $display("FAIL single_wen: got %h want 0008", wEnable); end
    tick();  // E2: WAIT
    n_cmp++; if (wEnable !== 16'h0000) begin n_fail++; $display("FAIL single_wait_wen: got %h want 0000", wEnable); end
    n_cmp++; if (opcode !== 8'h00) begin n_fail++; $display("FAIL single_wait_op: got %h want 00", opcode); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL single_early_done: got %b want 0", done); end
    Flags_in = 5'h15;
    tick();  // E3: retire
    Flags_in = 5'h00;
    n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL single_done: got %b want 1", done); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_end: got %b want 0", busy); end
    n_cmp++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL single_count_end: got %0d want 0", fifo_count); end
    n_cmp++; if (last_flags !== 5'h15) begin n_fail++; $display("FAIL single_last_flags: got %h want 15", last_flags); end
    tick();
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL single_done_width: got %b want 0", done); end
  endtask

  task automatic test_fib();
    int iss [3];
    int total    = 0;
    int dones    = 0;
    int bad_wait = 0;
    int bad_wen  = 0;
    for (int i = 0; i < 3; i++) iss[i] = 0;
    for (int c = 0; c < 80; c++) begin
      if (c < 3) drive_cmd(8'(8'h11 + c), 4'(c + 1), 4'd7, 1'b0, 16'(c), 1'b1, 4'd9, 5'd0);
      else cmd_valid = 1'b0;
      tick();
      if (opcode != 8'h00) begin
        total++;
        if (opcode >= 8'h11 && opcode <= 8'h13) iss[opcode - 8'h11]++;
        if (wEnable !== (16'h0001 << opcode[3:0])) bad_wen++;
      end else if (wEnable !== 16'h0000) begin
        bad_wait++;
      end
      if (done === 1'b1) dones++;
    end
    n_cmp++; if (total !== 30) begin n_fail++; $display("FAIL fib_total_issues: got %0d want 30", total); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (iss[i] !== 10) begin n_fail++; $display("FAIL fib_issues_cmd%0d: got %0d want 10", i, iss[i]); end
    end
    n_cmp++; if (dones !== 3) begin n_fail++; $display("FAIL fib_done_pulses: got %0d want 3", dones); end
    n_cmp++; if (bad_wait !== 0) begin n_fail++; $display("FAIL fib_wen_in_wait: got %0d cycles want 0", bad_wait); end
    n_cmp++; if (bad_wen !== 0) begin n_fail++; $display("FAIL fib_wen_decode: got %0d bad want 0", bad_wen); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL fib_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_overflow();
    int iss_a = 0;
    int iss_bcd = 0;
    int iss_e = 0;
    int dones = 0;
    for (int c = 0; c < 70; c++) begin
      if (c == 0) drive_cmd(8'h41, 4'd1, 4'd0, 1'b0, 16'h0, 1'b0, 4'd15, 5'd0);
      else if (c < 5) drive_cmd(8'(8'h41 + c), 4'd2, 4'd0, 1'b0, 16'h0, 1'b0, 4'd0, 5'd0);
      else cmd_valid = 1'b0;
      tick();
      if (c == 3) begin
        n_cmp++; if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL ovf_count_full: got %0d want 4", fifo_count); end
        n_cmp++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL ovf_ready_low: got %b want 0", cmd_ready); end
      end
      if (c == 4) begin
        n_cmp++; if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL ovf_count_after_drop: got %0d want 4", fifo_count); end
      end
      if (opcode == 8'h41) iss_a++;
      else if (opcode >= 8'h42 && opcode <= 8'h44) iss_bcd++;
      else if (opcode == 8'h45) iss_e++;
      if (done === 1'b1) dones++;
    end
    n_cmp++; if (iss_a !== 16) begin n_fail++; $display("FAIL ovf_issues_a: got %0d want 16", iss_a); end
    n_cmp++; if (iss_bcd !== 3) begin n_fail++; $display("FAIL ovf_issues_bcd: got %0d want 3", iss_bcd); end
    n_cmp++; if (iss_e !== 0) begin n_fail++; $display("FAIL ovf_dropped_issued: got %0d want 0", iss_e); end
    n_cmp++; if (dones !== 4) begin n_fail++; $display("FAIL ovf_done_pulses: got %0d want 4", dones); end
  endtask

  task automatic test_early_stop();
    int cnt = 0;
    int dones = 0;
`ifdef SEQ_FLAG_STOP_EN
    int exp_issues = 3;
    logic [4:0] exp_flags = 5'h01;
`else
    int exp_issues = 16;
    logic [4:0] exp_flags = 5'h00;
`endif
    for (int c = 0; c < 50; c++) begin
      if (c == 0) drive_cmd(8'h21, 4'd5, 4'd1, 1'b0, 16'h0, 1'b0, 4'd15, 5'h01);
      else cmd_valid = 1'b0;
      tick();
      if (opcode != 8'h00) cnt++;
      if (done === 1'b1) dones++;
      Flags_in = (cnt == 3) ? 5'h01 : 5'h00;  // high through the 3rd WAIT edge
    end
    Flags_in = 5'h00;
    n_cmp++; if (cnt !== exp_issues) begin n_fail++; $display("FAIL stop_issue_count: got %0d want %0d", cnt, exp_issues); end
    n_cmp++; if (dones !== 1) begin n_fail++; $display("FAIL stop_done_pulses: got %0d want 1", dones); end
    n_cmp++; if (last_flags !== exp_flags) begin n_fail++; $display("FAIL stop_last_flags: got %h want %h", last_flags, exp_flags); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_op = 8'h01;
    logic [7:0] next_push = 8'h01;
    int issued = 0;
    int dones = 0;
    for (int c = 0; c < 21; c++) begin
      if (c == 0 || c == 1 || c == 3 || c == 5 || c == 7 || c == 9) begin
        drive_cmd(next_push, next_push[3:0], 4'd0, 1'b0, 16'h0, 1'b1, 4'd0, 5'd0);
        next_push = next_push + 8'h01;
      end else begin
        cmd_valid = 1'b0;
      end
      tick();
      if (c == 3 || c == 5 || c == 7 || c == 9) begin
        n_cmp++; if (fifo_count !== 3'd2) begin n_fail++; $display("FAIL b2b_count_c%0d: got %0d want 2", c, fifo_count); end
      end
      if (opcode != 8'h00) begin
        n_cmp++; if (opcode !== exp_op) begin n_fail++; $display("FAIL b2b_order: got %h want %h", opcode, exp_op); end
        exp_op = exp_op + 8'h01;
        issued++;
      end
      if (done === 1'b1) dones++;
    end
    n_cmp++; if (issued !== 6) begin n_fail++; $display("FAIL b2b_issued: got %0d want 6", issued); end
    n_cmp++; if (dones !== 6) begin n_fail++; $display("FAIL b2b_done_pulses: got %0d want 6", dones); end
  endtask

  task automatic test_reset_mid();
    logic found = 1'b0;
    int dones = 0;
    int issues = 0;
    for (int c = 0; c < 40; c++) begin
      if (c < 3) drive_cmd(8'(8'h31 + c), 4'd4, 4'd0, 1'b0, 16'h0, 1'b1, 4'd1, 5'd0);
      else cmd_valid = 1'b0;
      tick();
      if (opcode == 8'h32) begin
        found = 1'b1;
        break;
      end
    end
    cmd_valid = 1'b0;
    n_cmp++; if (found !== 1'b1) begin n_fail++; $display("FAIL rmid_timeout: got no issue of 32 want one within 40 cycles"); end
    tick();  // WAIT of the 2nd command
    n_cmp++; if (fifo_count !== 3'd2) begin n_fail++; $display("FAIL rmid_count_before: got %0d want 2", fifo_count); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL rmid_count: got %0d want 0", fifo_count); end
    n_cmp++; if (wEnable !== 16'h0000) begin n_fail++; $display("FAIL rmid_wen: got %h want 0000", wEnable); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL rmid_done: got %b want 0", done); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b want 0", busy); end
    n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_ready: got %b want 1", cmd_ready); end
    for (int c = 0; c < 8; c++) begin
      tick();
      if (done === 1'b1) dones++;
      if (opcode != 8'h00) issues++;
    end
    n_cmp++; if (dones !== 0) begin n_fail++; $display("FAIL rmid_late_done: got %0d want 0", dones); end
    n_cmp++; if (issues !== 0) begin n_fail++; $display("FAIL rmid_late_issue: got %0d want 0", issues); end
  endtask

  initial begin
    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_opcode = 8'd0; cmd_rdest = 4'd0; cmd_rsrc = 4'd0; cmd_imm_sel = 1'b0;
    cmd_imm = 16'd0; cmd_wb = 1'b0; cmd_repeat = 4'd0; cmd_stop_mask = 5'd0;
    Flags_in = 5'd0;
    test_reset();
    test_single();
    test_fib();
    test_overflow();
    test_early_stop();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/datapath_sequencer.md
DATAPATH_SEQUENCER -- requirements
Module: datapath_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, command FIFO depth (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports cmd_valid input 1 and cmd_ready output 1: command push handshake.
REQ-005 SHALL have ports cmd_opcode input 8, cmd_rdest input 4, cmd_rsrc input 4, cmd_imm_sel input 1, cmd_imm input 16 and cmd_wb input 1 (write-back enable).
REQ-006 SHALL have ports cmd_repeat input 4 (issue count minus one) and cmd_stop_mask input 5.
REQ-007 SHALL have ports opcode output 8, Rdest_sel output 4, Rsrc_sel output 4, Imm_sel output 1, Imm_in output 16 and wEnable output 16, all driving the register-file/ALU datapath.
REQ-008 SHALL have port Flags_in  input  5  datapath flags, registered by the datapath on the issue edge.
REQ-009 SHALL have ports busy output 1, done output 1, fifo_count output $clog2(DEPTH)+1 and last_flags output 5.

Function
REQ-010 A push SHALL occur on a rising edge with cmd_valid and cmd_ready both high; cmd_ready SHALL be (fifo_count < DEPTH), with no bypass for a same-cycle pop.
REQ-011 The FSM SHALL have states IDLE, ISSUE and WAIT; IDLE->ISSUE on the edge after which the FIFO is non-empty, and ISSUE->WAIT unconditionally.
REQ-012 In ISSUE, the outputs SHALL drive the head entry: opcode, Rdest_sel, Rsrc_sel, Imm_sel and Imm_in; wEnable SHALL be the one-hot of cmd_rdest if cmd_wb=1, else 0.
REQ-013 In IDLE and WAIT, opcode, Rdest_sel, Rsrc_sel, Imm_sel, Imm_in and wEnable SHALL all be 0, so the datapath performs no write.
REQ-014 On the WAIT->next edge, last_flags SHALL capture Flags_in.
REQ-015 On the WAIT->next edge, the repeat counter (loaded from cmd_repeat on the first issue of an entry) SHALL be tested: if nonzero and not stopped, decrement it and return to ISSUE with the same entry.
REQ-016 Otherwise the head SHALL be popped, done SHALL pulse high for exactly one cycle, and the FSM SHALL go to ISSUE if another entry remains, else IDLE.
REQ-017 Each repetition SHALL take exactly 2 cycles; a push at edge E0 into an empty idle sequencer SHALL issue in cycle E1-E2, and done SHALL be high in cycle E3-E4 for cmd_repeat=0.
REQ-018 cmd_repeat=15 SHALL give 16 issues; the counter SHALL never wrap below 0.
REQ-019 busy SHALL be high whenever the state is not IDLE or fifo_count is nonzero.
REQ-020 FIFO pointers SHALL wrap modulo DEPTH; a simultaneous push and pop SHALL leave fifo_count unchanged.
REQ-021 A push when full SHALL be ignored, and FIFO contents SHALL be unchanged.

Reset
REQ-022 After any rising edge with reset=1, the state SHALL be IDLE and the FIFO SHALL be empty.
REQ-023 After such an edge, fifo_count, the repeat counter, last_flags, done and all datapath outputs SHALL be 0, and cmd_ready SHALL be 1.
REQ-024 Reset mid-ISSUE or mid-WAIT SHALL abandon the current and all queued commands with no done pulse.

Configuration
REQ-025 With macro SEQ_FLAG_STOP_EN defined: if (Flags_in & cmd_stop_mask) != 0 at the WAIT edge, the remaining repeats SHALL be abandoned, with pop and done as in REQ-016.
REQ-026 Without SEQ_FLAG_STOP_EN: the cmd_stop_mask port SHALL remain present but be ignored, and every entry SHALL run cmd_repeat+1 issues.

Verification
REQ-027 Single command: opcode=0x05, rdest=3, rsrc=2, wb=1, repeat=0 -> one ISSUE cycle with wEnable=0x0008, then done one cycle later, then busy=0.
REQ-028 Fibonacci-style sequence: push 3 commands with repeat=9 -> 30 ISSUE cycles total, wEnable never high in WAIT cycles, and 3 done pulses.
REQ-029 Fill and overflow (DEPTH=4): push 5 commands back-to-back while stalled -> cmd_ready low after 4 pushes, the 5th is dropped, and fifo_count=4.
REQ-030 Early stop with SEQ_FLAG_STOP_EN: repeat=15, stop_mask=0x01, Flags_in[0]=1 at the 3rd WAIT -> exactly 3 issues, then done; without the macro -> 16 issues.
REQ-031 Reset asserted during the WAIT of the 2nd of 3 queued commands -> next cycle IDLE, fifo_count=0, wEnable=0 and no done pulse.
REQ-032 Simultaneous push and pop at fifo_count=2 -> fifo_count stays 2 and the order is preserved (checked by a sequence of distinct opcodes 0x01..0x06).
